// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the core's single ALU.
// While idle the core drives the ALU. While a multiply runs the core is stalled.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef SHAMT_WIDTH
`define SHAMT_WIDTH 5
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif

module alu_mul_seq #(
  parameter int WORD_WIDTH  = `WORD_WIDTH,
  parameter int SHAMT_WIDTH = `SHAMT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             core_function,
  input  logic [WORD_WIDTH-1:0]  core_src1,
  input  logic [WORD_WIDTH-1:0]  core_src2,
  input  logic [SHAMT_WIDTH-1:0] core_shamt,
  output logic                   core_stall,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  multiplicand,
  input  logic [WORD_WIDTH-1:0]  multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_WIDTH-1:0]  product,
  output logic [3:0]             alu_function,
  output logic [WORD_WIDTH-1:0]  alu_src1,
  output logic [WORD_WIDTH-1:0]  alu_src2,
  output logic [SHAMT_WIDTH-1:0] alu_shamt,
  input  logic [WORD_WIDTH-1:0]  alu_result
);

  localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] acc;
  logic [WORD_WIDTH-1:0] mcand;
  logic [WORD_WIDTH-1:0] mplier;
  logic [CW-1:0]         cnt;
  logic                  last;

  // Stop as soon as no multiplier bits remain, or after the final bit position.
  assign last = ((mplier >> 1) == '0) || (cnt == CNT_LAST);

  always_comb begin
    alu_function = core_function;
    alu_src1     = core_src1;
    alu_src2     = core_src2;
    alu_shamt    = core_shamt;
    if (state == S_RUN) begin
      alu_function = `ALU_ADD;
      alu_src1     = acc;
      alu_src2     = mplier[0] ? mcand : '0;
      alu_shamt    = '0;
    end
    busy       = (state != S_IDLE);
    core_stall = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            product <= alu_result;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that shares the single ALU with the core. While idle it passes the core's ALU controls straight through. On `start` it takes over the ALU and runs a shift-add multiply with one `ALU_ADD` per cycle, terminating early. Meanwhile it stalls the core, then returns the low `WORD_WIDTH` bits of the product.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (32): operand/result width.
- `SHAMT_WIDTH`, default `` `SHAMT_WIDTH `` (5): shift-amount width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_function` in 4: core's ALU function request.
- `core_src1`, `core_src2` in WORD_WIDTH: core's ALU operands.
- `core_shamt` in SHAMT_WIDTH: core's shift amount.
- `core_stall` out 1: core must hold its pipeline; ALU not available.
- `start` in 1: begin multiply; sampled only in IDLE.
- `multiplicand`, `multiplier` in WORD_WIDTH: operands, sampled with `start`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; `product` valid.
- `product` out WORD_WIDTH: registered result, held until next accepted `start`.
- `alu_function` out 4, `alu_src1`/`alu_src2` out WORD_WIDTH, `alu_shamt` out SHAMT_WIDTH: drive the shared ALU.
- `alu_result` in WORD_WIDTH: ALU output (combinational from the above).

## Operation
- State machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - ALU outputs equal the `core_*` inputs combinationally.
  - `core_stall`=0.
  - `start`=1 loads `mcand`←`multiplicand`, `mplier`←`multiplier`, `acc`←0, `cnt`←0, and moves to RUN.
- **RUN**, each cycle:
  - `alu_function`=`ALU_ADD`, `alu_src1`=`acc`, `alu_src2`=`mplier[0] ? mcand : 0`, `alu_shamt`=0.
  - `acc`←`alu_result`, `mcand`←`mcand<<1`, `mplier`←`mplier>>1`, `cnt`←`cnt+1`.
  - Goes to DONE when `(mplier>>1)==0` or `cnt==WORD_WIDTH-1`. On that transition `product`←`alu_result`.
  - Core inputs are ignored.
- **DONE**
  - `done`=1 for exactly this cycle.
  - ALU outputs revert to core pass-through; `core_stall` stays 1.
  - Next state is IDLE unconditionally.
- `core_stall` = `busy` = (state != IDLE).
- `start` in RUN or DONE is ignored: no queueing, no restart.
- Arithmetic:
  - Modulo 2^WORD_WIDTH; carries out of `acc` and bits shifted out of `mcand` are discarded.
  - The result equals the low word of both the signed and the unsigned product.
- **Reset**, at any time including mid-RUN:
  - State←IDLE; `acc`, `mcand`, `mplier`, `cnt`, `product`←0; `done`=0.
  - The multiply in progress is aborted, with no `done` pulse.
- Reset values of outputs:
  - `core_stall`=0, `busy`=0, `done`=0, `product`=0.
  - ALU outputs equal the `core_*` inputs.

## Timing
- `start` is accepted at edge 0 (IDLE). RUN occupies cycles 1..k+1, where k is the index of the highest set bit of `multiplier`; k=0 when `multiplier`=0.
- `done`=1 and `product` is valid in cycle k+2. The block is back in IDLE in cycle k+3 and can accept `start` there.
- Latency ranges:
  - `multiplier`=0 or 1: `done` in cycle 2 (minimum).
  - MSB set: 32 RUN cycles, `done` in cycle 33 (maximum).
- `core_stall` rises in cycle 1 (the first RUN cycle) and falls in cycle k+3. The core ALU request issued in cycle 0 is served by pass-through in that same cycle.
- `product` changes only on the RUN→DONE edge or on reset.

## Test plan
- **Reset:** assert `rst` 2 cycles with random `core_*` inputs. Require `product`=0, `done`=0, `busy`=0, `core_stall`=0, and `alu_src1`=`core_src1` in the same cycle.
- **Basic multiply:** `start`, 3 × 5. Require RUN for 3 cycles, `done` in cycle 4 with `product`=15, and IDLE in cycle 5.
- **Signed operands, held result:** -7 (0xFFFFFFF9) × 6. Require `product`=0xFFFFFFD6 with `done` in cycle 4, and `product` held after a further 10 idle cycles.
- **Latency bounds:**
  - 0x12345678 × 0: require `product`=0, `done` in cycle 2.
  - 0xFFFFFFFF × 0xFFFFFFFF: require `product`=1, `done` in cycle 33, and `alu_function`=`ALU_ADD` throughout RUN.
- **Sharing:**
  - In IDLE drive `core_function`=`ALU_SUB` with 10, 3: require `alu_result`=7 and `core_stall`=0.
  - During RUN, toggle `core_*` and pulse `start` with new operands: require the ALU is still driven by the sequencer, the original product is correct, and the second `start` is ignored.
- **Reset mid-run:** start 0xFFFFFFFF × 0xFFFFFFFF and assert `rst` at cycle 10. Require IDLE, `product`=0 and no `done` pulse. A following 2 × 2 must give `done` in cycle 3 with `product`=4.
